// File: rtl/multi_view_compositor_if.sv
// rtl/multi_view_compositor_if.sv - video timing, render and composed pixel bus of the multi-view compositor
// master drives timing/mode/view colours, slave (the compositor) returns render coordinates and pixels.
interface multi_view_compositor_if #(
  parameter int NUM_VIEWS   = 2,
  parameter int COLOR_WIDTH = 8
);
  logic [10:0]                      hcount_in;
  logic [9:0]                       vcount_in;
  logic                             hs_in;
  logic                             vs_in;
  logic                             ad_in;
  logic                             nf_in;
  logic [1:0]                       mode_in;
  logic [1:0]                       view_sel_in;
  logic [10:0]                      view_hcount_out;
  logic [9:0]                       view_vcount_out;
  logic [NUM_VIEWS*COLOR_WIDTH-1:0] view_color_in;
  logic [COLOR_WIDTH-1:0]           red_out;
  logic [COLOR_WIDTH-1:0]           green_out;
  logic [COLOR_WIDTH-1:0]           blue_out;
  logic                             hs_out;
  logic                             vs_out;
  logic                             ad_out;
  logic [1:0]                       active_view_out;

  modport master (
    output hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, mode_in, view_sel_in, view_color_in,
    input  view_hcount_out, view_vcount_out, red_out, green_out, blue_out,
           hs_out, vs_out, ad_out, active_view_out
  );

  modport slave (
    input  hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, mode_in, view_sel_in, view_color_in,
    output view_hcount_out, view_vcount_out, red_out, green_out, blue_out,
           hs_out, vs_out, ad_out, active_view_out
  );
endinterface

// File: rtl/multi_view_compositor.sv
// rtl/multi_view_compositor.sv - per-view render coordinates, tag realignment and RGB composition
// Optional crosshair overlay enabled by defining COMPOSITOR_CROSSHAIR_EN.
module multi_view_compositor #(
  parameter int NUM_VIEWS      = 2,
  parameter int COLOR_WIDTH    = 8,
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 720,
  parameter int SCALE_SHIFT    = 2,
  parameter int RENDER_LATENCY = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  multi_view_compositor_if.slave bus
);
  localparam logic [10:0] H_HALF    = 11'(H_ACTIVE / 2);
  localparam logic [2:0]  NV        = 3'(NUM_VIEWS);
  localparam logic [1:0]  LAST_VIEW = 2'(NUM_VIEWS - 1);
`ifdef COMPOSITOR_CROSSHAIR_EN
  localparam logic [9:0]  V_HALF    = 10'(V_ACTIVE / 2);
`endif

  typedef enum logic [1:0] {
    MODE_ANAGLYPH = 2'd0,
    MODE_SBS      = 2'd1,
    MODE_SINGLE   = 2'd2,
    MODE_FRAMESEQ = 2'd3
  } mode_t;

  typedef struct packed {
`ifdef COMPOSITOR_CROSSHAIR_EN
    logic [10:0] h;
    logic [9:0]  v;
`endif
    logic [1:0]  view;
    logic        anag;
    logic        ad;
    logic        hs;
    logic        vs;
  } tag_t;

  mode_t      mode_q;
  mode_t      mode_new;
  logic [1:0] sel_q;
  logic [1:0] cnt_q;
  logic       sel_ok;

  // A single renderer has nothing to pair or alternate with, so every mode collapses to single view.
  always_comb begin
    mode_new = mode_t'(bus.mode_in);
    if (NUM_VIEWS == 1) mode_new = MODE_SINGLE;
  end

  assign sel_ok = {1'b0, bus.view_sel_in} < NV;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mode_q <= MODE_ANAGLYPH;
      sel_q  <= 2'd0;
      cnt_q  <= 2'd0;
    end else if (bus.nf_in) begin
      mode_q <= mode_new;
      sel_q  <= sel_ok ? bus.view_sel_in : 2'd0;
      if (mode_new == MODE_FRAMESEQ)
        cnt_q <= (mode_q != MODE_FRAMESEQ || cnt_q == LAST_VIEW) ? 2'd0 : cnt_q + 2'd1;
      else
        cnt_q <= 2'd0;
    end
  end

  assign bus.active_view_out = cnt_q;

  logic        half;
  logic [10:0] h_fold;
  logic [10:0] h_view;
  tag_t        tag_new;
  tag_t        tag_c;

  assign half   = bus.hcount_in >= H_HALF;
  assign h_fold = half ? bus.hcount_in - H_HALF : bus.hcount_in;

  // Uses the mode latched before this edge, so a tag issued on the nf_in cycle keeps the old route.
  always_comb begin
    h_view       = bus.hcount_in >> SCALE_SHIFT;
    tag_new      = '0;
    tag_new.anag = (mode_q == MODE_ANAGLYPH);
    tag_new.ad   = bus.ad_in;
    tag_new.hs   = bus.hs_in;
    tag_new.vs   = bus.vs_in;
`ifdef COMPOSITOR_CROSSHAIR_EN
    tag_new.h    = bus.hcount_in;
    tag_new.v    = bus.vcount_in;
`endif
    case (mode_q)
      MODE_SBS: begin
        h_view       = {h_fold[9:0], 1'b0} >> SCALE_SHIFT;
        tag_new.view = {1'b0, half};
      end
      MODE_SINGLE:   tag_new.view = sel_q;
      MODE_FRAMESEQ: tag_new.view = cnt_q;
      default:       tag_new.view = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.view_hcount_out <= '0;
      bus.view_vcount_out <= '0;
      tag_c               <= '0;
    end else begin
      tag_c <= tag_new;
      if (bus.ad_in) begin
        bus.view_hcount_out <= h_view;
        bus.view_vcount_out <= bus.vcount_in >> SCALE_SHIFT;
      end
    end
  end

  // Tag rides alongside the renderers so its last stage lines up with the returned colours.
  tag_t pipe [RENDER_LATENCY];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RENDER_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_c;
      for (int i = 1; i < RENDER_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic [COLOR_WIDTH-1:0] views [4];

  for (genvar k = 0; k < 4; k++) begin : g_view
    if (k < NUM_VIEWS) begin : g_live
      assign views[k] = bus.view_color_in[k*COLOR_WIDTH +: COLOR_WIDTH];
    end else begin : g_pad
      assign views[k] = '0;
    end
  end

  tag_t                   tag_d;
  logic [COLOR_WIDTH-1:0] red_n;
  logic [COLOR_WIDTH-1:0] green_n;
  logic [COLOR_WIDTH-1:0] blue_n;

  assign tag_d = pipe[RENDER_LATENCY-1];

  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    if (tag_d.ad) begin
      if (tag_d.anag) begin
        red_n  = views[0];
        blue_n = views[1];
      end else begin
        red_n   = views[tag_d.view];
        green_n = views[tag_d.view];
        blue_n  = views[tag_d.view];
      end
`ifdef COMPOSITOR_CROSSHAIR_EN
      if (tag_d.h == H_HALF || tag_d.v == V_HALF) begin
        red_n   = '1;
        green_n = '1;
        blue_n  = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.red_out   <= '0;
      bus.green_out <= '0;
      bus.blue_out  <= '0;
      bus.hs_out    <= 1'b0;
      bus.vs_out    <= 1'b0;
      bus.ad_out    <= 1'b0;
    end else begin
      bus.red_out   <= red_n;
      bus.green_out <= green_n;
      bus.blue_out  <= blue_n;
      bus.hs_out    <= tag_d.hs;
      bus.vs_out    <= tag_d.vs;
      bus.ad_out    <= tag_d.ad;
    end
  end
endmodule
